// File: rtl/m3ds_ahb_slave_mux.sv
// m3ds_ahb_slave_mux
//
// Data-phase response multiplexer for the M3 DesignStart peripherals AHB.
// Registers the address decoder's HSELs (after a fixed priority resolve) at
// every address-phase boundary. During the following data phase it steers the
// selected slave's HREADYOUT/HRESP/HRDATA back to the master. It also contains
// the default slave, which gives a two-cycle ERROR response to every
// NONSEQ/SEQ transfer that reaches it.
//
// Handshake: HREADY high at a rising HCLK edge ends the current data phase
// and accepts the address phase presented with it. HREADYOUT low from the
// selected slave stretches the data phase. While HREADY is low, every
// decoder input is ignored.
//
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   HREADY, HTRANS1        bus ready (fed back), HTRANS[1] of the address phase
//   HSEL0                  decoder select for the default slave
//   HSEL2..HSEL6           decoder selects: GPIO0..GPIO3, SysCtrl
//   HREADYOUT2..6          slave ready inputs
//   HRESP2..6              slave responses (1 = ERROR)
//   HRDATA2..6             slave read data
//   HREADYOUT, HRESP       muxed response to the master
//   HRDATA                 muxed read data
//   dbg_state              default-slave FSM state (0 IDLE, 1 ERR1, 2 ERR2)

module m3ds_ahb_slave_mux #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HREADY,
    input  logic                  HTRANS1,
    input  logic                  HSEL0,
    input  logic                  HSEL2,
    input  logic                  HSEL3,
    input  logic                  HSEL4,
    input  logic                  HSEL5,
    input  logic                  HSEL6,
    input  logic                  HREADYOUT2,
    input  logic                  HREADYOUT3,
    input  logic                  HREADYOUT4,
    input  logic                  HREADYOUT5,
    input  logic                  HREADYOUT6,
    input  logic                  HRESP2,
    input  logic                  HRESP3,
    input  logic                  HRESP4,
    input  logic                  HRESP5,
    input  logic                  HRESP6,
    input  logic [DATA_WIDTH-1:0] HRDATA2,
    input  logic [DATA_WIDTH-1:0] HRDATA3,
    input  logic [DATA_WIDTH-1:0] HRDATA4,
    input  logic [DATA_WIDTH-1:0] HRDATA5,
    input  logic [DATA_WIDTH-1:0] HRDATA6,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    // Bit order: [0] default, [1] GPIO0, [2] GPIO1, [3] GPIO2, [4] GPIO3,
    // [5] SysCtrl.
    logic [5:0] sel_res;
    logic [5:0] sel_q;
    state_t     state_q;
    state_t     state_d;
    logic       dflt_start;
    logic       dflt_ready;
    logic       dflt_resp;
    logic       no_sel;

    // Keep only the highest-priority select so sel_q can never be multi-hot.
    always_comb begin
        sel_res    = 6'b0;
        sel_res[0] = HSEL0;
        sel_res[1] = HSEL2 & ~HSEL0;
        sel_res[2] = HSEL3 & ~HSEL2 & ~HSEL0;
        sel_res[3] = HSEL4 & ~HSEL3 & ~HSEL2 & ~HSEL0;
        sel_res[4] = HSEL5 & ~HSEL4 & ~HSEL3 & ~HSEL2 & ~HSEL0;
        sel_res[5] = HSEL6 & ~HSEL5 & ~HSEL4 & ~HSEL3 & ~HSEL2 & ~HSEL0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q <= 6'b0;
        end else if (HREADY) begin
            sel_q <= sel_res;
        end
    end

    // An active transfer to the default slave accepted at this edge.
    assign dflt_start = HREADY & sel_res[0] & HTRANS1;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dflt_ready = 1'b1;
        dflt_resp  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dflt_start) state_d = ST_ERR1;
            end
            ST_ERR1: begin
                dflt_ready = 1'b0;
                dflt_resp  = 1'b1;
                state_d    = ST_ERR2;
            end
            ST_ERR2: begin
                dflt_resp = 1'b1;
                state_d   = dflt_start ? ST_ERR1 : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dbg_state = state_q;

    // With no slave selected the data phase is a zero-wait OKAY.
    assign no_sel = ~|sel_q;

    // AND-OR mux: sel_q is one-hot or zero, so at most one term contributes
    // and HRDATA is all zeros (never X) when nothing is selected.
    always_comb begin
        HREADYOUT = no_sel
                  | (sel_q[0] & dflt_ready)
                  | (sel_q[1] & HREADYOUT2)
                  | (sel_q[2] & HREADYOUT3)
                  | (sel_q[3] & HREADYOUT4)
                  | (sel_q[4] & HREADYOUT5)
                  | (sel_q[5] & HREADYOUT6);
        HRESP     = (sel_q[0] & dflt_resp)
                  | (sel_q[1] & HRESP2)
                  | (sel_q[2] & HRESP3)
                  | (sel_q[3] & HRESP4)
                  | (sel_q[4] & HRESP5)
                  | (sel_q[5] & HRESP6);
        HRDATA    = ({DATA_WIDTH{sel_q[1]}} & HRDATA2)
                  | ({DATA_WIDTH{sel_q[2]}} & HRDATA3)
                  | ({DATA_WIDTH{sel_q[3]}} & HRDATA4)
                  | ({DATA_WIDTH{sel_q[4]}} & HRDATA5)
                  | ({DATA_WIDTH{sel_q[5]}} & HRDATA6);
    end

endmodule

// File: tb/tb_m3ds_ahb_slave_mux.sv
// tb_m3ds_ahb_slave_mux
//
// Bench for m3ds_ahb_slave_mux. HREADY is fed back from HREADYOUT as on the
// real bus. A behavioural model tracks which slave owns the data phase and
// how far into an ERROR response the default slave is; expected outputs come
// from that model and from directed constants.

module tb_m3ds_ahb_slave_mux;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic         htrans1;
    logic [6:0]   hsel;          // index = slave number, bit 1 unused
    logic [6:0]   hreadyout_s;
    logic [6:0]   hresp_s;
    logic [W-1:0] hrdata_s [7];
    logic         hready;
    logic         hready_out;
    logic         hresp_out;
    logic [W-1:0] hrdata_out;
    logic [1:0]   dbg_state;

    assign hready = hready_out;

    m3ds_ahb_slave_mux #(.DATA_WIDTH(W)) dut (
        .HCLK       (clk),
        .HRESETn    (rst_n),
        .HREADY     (hready),
        .HTRANS1    (htrans1),
        .HSEL0      (hsel[0]),
        .HSEL2      (hsel[2]),
        .HSEL3      (hsel[3]),
        .HSEL4      (hsel[4]),
        .HSEL5      (hsel[5]),
        .HSEL6      (hsel[6]),
        .HREADYOUT2 (hreadyout_s[2]),
        .HREADYOUT3 (hreadyout_s[3]),
        .HREADYOUT4 (hreadyout_s[4]),
        .HREADYOUT5 (hreadyout_s[5]),
        .HREADYOUT6 (hreadyout_s[6]),
        .HRESP2     (hresp_s[2]),
        .HRESP3     (hresp_s[3]),
        .HRESP4     (hresp_s[4]),
        .HRESP5     (hresp_s[5]),
        .HRESP6     (hresp_s[6]),
        .HRDATA2    (hrdata_s[2]),
        .HRDATA3    (hrdata_s[3]),
        .HRDATA4    (hrdata_s[4]),
        .HRDATA5    (hrdata_s[5]),
        .HRDATA6    (hrdata_s[6]),
        .HREADYOUT  (hready_out),
        .HRESP      (hresp_out),
        .HRDATA     (hrdata_out),
        .dbg_state  (dbg_state)
    );

    // ---------------- reference model ----------------
    int n_checks;
    int n_fail;
    int owner;    // -1 none, 0 default slave, 2..6 peripheral slaves
    int err_ph;   // 0 no error, 1 first error cycle, 2 second error cycle

    logic         e_rdy;
    logic         e_resp;
    logic [W-1:0] e_data;

    function automatic int winner(input logic [6:0] s);
        int order [6] = '{0, 2, 3, 4, 5, 6};
        for (int k = 0; k < 6; k++) begin
            if (s[order[k]]) return order[k];
        end
        return -1;
    endfunction

    task automatic model_expect();
        if (owner < 0) begin
            e_rdy = 1'b1; e_resp = 1'b0; e_data = '0;
        end else if (owner == 0) begin
            e_rdy  = (err_ph != 1);
            e_resp = (err_ph != 0);
            e_data = '0;
        end else begin
            e_rdy  = hreadyout_s[owner];
            e_resp = hresp_s[owner];
            e_data = hrdata_s[owner];
        end
    endtask

    task automatic model_reset();
        owner  = -1;
        err_ph = 0;
    endtask

    // Advance one clock: capture the pre-edge bus, step the model, settle.
    task automatic tick();
        logic       hr;
        logic [6:0] hs;
        logic       ht;
        int         w;
        int         nxt;
        hr = hready;
        hs = hsel;
        ht = htrans1;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            w = winner(hs);
            if (err_ph == 1)                 nxt = 2;
            else if (hr && w == 0 && ht)     nxt = 1;
            else                             nxt = 0;
            if (hr) owner = w;
            err_ph = nxt;
        end
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic bus_quiet();
        hsel        = '0;
        htrans1     = 1'b0;
        hreadyout_s = '1;
        hresp_s     = '0;
        for (int k = 0; k < 7; k++) hrdata_s[k] = $urandom;
    endtask

    task automatic settle();
        bus_quiet();
        tick();
        tick();
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus_quiet();
        rst_n = 1'b0;
        model_reset();
        #12;
        n_checks++;
        if (hready_out !== 1'b1 || hresp_out !== 1'b0 || hrdata_out !== '0) begin
            n_fail++;
            $display("FAIL reset_asserted: got rdy=%b resp=%b data=%h want 1/0/0",
                     hready_out, hresp_out, hrdata_out);
        end
        // IDLE is encoded as zero on the debug port.
        n_checks++;
        if (dbg_state !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state: got %b want 00", dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (hready_out !== 1'b1 || hresp_out !== 1'b0 || hrdata_out !== '0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got rdy=%b resp=%b data=%h want 1/0/0",
                         i, hready_out, hresp_out, hrdata_out);
            end
        end
        tick();
    endtask

    task automatic test_gpio1_wait();
        settle();
        hsel[3]        = 1'b1;
        htrans1        = 1'b1;
        hrdata_s[3]    = 32'hA5A5_0003;
        hreadyout_s[3] = 1'b0;
        tick();
        hsel    = '0;
        htrans1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hsel[6] = (i == 1);
            @(negedge clk);
            model_expect();
            n_checks++;
            if (hready_out !== 1'b0 || hready_out !== e_rdy || hresp_out !== e_resp) begin
                n_fail++;
                $display("FAIL gpio1_wait[%0d]: got rdy=%b resp=%b want rdy=0 resp=%b",
                         i, hready_out, hresp_out, e_resp);
            end
            tick();
        end
        hsel[6]        = 1'b0;
        hreadyout_s[3] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (hready_out !== 1'b1 || hresp_out !== 1'b0 || hrdata_out !== 32'hA5A5_0003) begin
            n_fail++;
            $display("FAIL gpio1_done: got rdy=%b resp=%b data=%h want 1/0/a5a50003",
                     hready_out, hresp_out, hrdata_out);
        end
        tick();
    endtask

    task automatic test_back_to_back_error();
        logic exp_rdy  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic exp_resp [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        settle();
        hsel[0] = 1'b1;
        htrans1 = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 3) htrans1 = 1'b0;
            @(negedge clk);
            model_expect();
            n_checks++;
            if (hready_out !== exp_rdy[i] || hresp_out !== exp_resp[i] ||
                hready_out !== e_rdy || hresp_out !== e_resp || hrdata_out !== '0) begin
                n_fail++;
                $display("FAIL b2b_error[%0d]: got rdy=%b resp=%b data=%h want %b/%b/0",
                         i, hready_out, hresp_out, hrdata_out, exp_rdy[i], exp_resp[i]);
            end
            tick();
        end
    endtask

    task automatic test_idle_hsel0();
        settle();
        hsel[0] = 1'b1;
        htrans1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (hready_out !== 1'b1 || hresp_out !== 1'b0 || hrdata_out !== '0) begin
                n_fail++;
                $display("FAIL idle_hsel0[%0d]: got rdy=%b resp=%b data=%h want 1/0/0",
                         i, hready_out, hresp_out, hrdata_out);
            end
        end
        tick();
    endtask

    task automatic test_priority();
        settle();
        hsel[0]     = 1'b1;
        hsel[4]     = 1'b1;
        htrans1     = 1'b1;
        hrdata_s[4] = 32'hDEAD_BEEF;
        tick();
        hsel    = '0;
        htrans1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hready_out !== 1'b0 || hresp_out !== 1'b1 || hrdata_out !== '0) begin
            n_fail++;
            $display("FAIL prio_default: got rdy=%b resp=%b data=%h want 0/1/0",
                     hready_out, hresp_out, hrdata_out);
        end
        tick();
        tick();
        hsel[2]     = 1'b1;
        hsel[5]     = 1'b1;
        htrans1     = 1'b1;
        hrdata_s[2] = $urandom;
        hrdata_s[5] = ~hrdata_s[2];
        tick();
        hsel    = '0;
        htrans1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hready_out !== 1'b1 || hresp_out !== 1'b0 || hrdata_out !== hrdata_s[2]) begin
            n_fail++;
            $display("FAIL prio_gpio0: got rdy=%b resp=%b data=%h want 1/0/%h",
                     hready_out, hresp_out, hrdata_out, hrdata_s[2]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        // Reset during ERR1.
        settle();
        hsel[0] = 1'b1;
        htrans1 = 1'b1;
        tick();
        hsel    = '0;
        htrans1 = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (hready_out !== 1'b1 || hresp_out !== 1'b0 || hrdata_out !== '0) begin
            n_fail++;
            $display("FAIL reset_in_err1: got rdy=%b resp=%b data=%h want 1/0/0",
                     hready_out, hresp_out, hrdata_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // Reset during a SysCtrl wait state.
        hsel[6]        = 1'b1;
        htrans1        = 1'b1;
        hreadyout_s[6] = 1'b0;
        hresp_s[6]     = 1'b1;
        tick();
        hsel    = '0;
        htrans1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hready_out !== 1'b0 || hresp_out !== 1'b1) begin
            n_fail++;
            $display("FAIL sysctrl_wait: got rdy=%b resp=%b want 0/1", hready_out, hresp_out);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (hready_out !== 1'b1 || hresp_out !== 1'b0 || hrdata_out !== '0) begin
            n_fail++;
            $display("FAIL reset_in_wait: got rdy=%b resp=%b data=%h want 1/0/0",
                     hready_out, hresp_out, hrdata_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_quiet();
        tick();
        // GPIO3 read afterwards completes with zero wait.
        hsel[5]     = 1'b1;
        htrans1     = 1'b1;
        hrdata_s[5] = 32'h0000_1234;
        tick();
        hsel    = '0;
        htrans1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hready_out !== 1'b1 || hresp_out !== 1'b0 || hrdata_out !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL gpio3_after_reset: got rdy=%b resp=%b data=%h want 1/0/00001234",
                     hready_out, hresp_out, hrdata_out);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 7; k++) begin
                hsel[k]        = (k != 1) && ($urandom_range(99) < 25);
                hreadyout_s[k] = ($urandom_range(99) < 70);
                hresp_s[k]     = ($urandom_range(99) < 20);
                hrdata_s[k]    = $urandom;
            end
            htrans1 = ($urandom_range(99) < 70);
            @(negedge clk);
            model_expect();
            n_checks++;
            if (hready_out !== e_rdy || hresp_out !== e_resp || hrdata_out !== e_data) begin
                n_fail++;
                $display("FAIL random[%0d]: got rdy=%b resp=%b data=%h want %b/%b/%h",
                         i, hready_out, hresp_out, hrdata_out, e_rdy, e_resp, e_data);
            end
            tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        test_reset();
        test_gpio1_wait();
        test_back_to_back_error();
        test_idle_hsel0();
        test_priority();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
